// File: rtl/axis_keep_pack_pkg.sv
// Shared types and keep-mask helpers for the AXI4-Stream keep repacker.
package axis_keep_pack_pkg;

    // Widest supported bus is 512 bits, so 64 byte lanes.
    localparam int KEEP_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic       contig;
        logic [7:0] count;
    } keep_info_t;

    function automatic logic [KEEP_MAX-1:0] keep_ones(input int n);
        logic [KEEP_MAX-1:0] m;
        for (int i = 0; i < KEEP_MAX; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    // Callers zero-extend the mask, so lanes above the bus width never count.
    function automatic keep_info_t keep_count(input logic [KEEP_MAX-1:0] mask);
        keep_info_t info;
        int         cnt;
        cnt = 0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (mask[i]) begin
                cnt++;
            end
        end
        info.count  = 8'(cnt);
        info.contig = (mask == keep_ones(cnt));
        return info;
    endfunction

endpackage

// File: rtl/axis_keep_pack_out_reg.sv
// Single registered output slot; loads whenever the slot is empty or being drained.
module axis_out_reg #(
    parameter int BUS_WIDTH  = 512,
    parameter int KEEP_WIDTH = BUS_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  ARESET,
    input  logic                  push_valid,
    input  logic [BUS_WIDTH-1:0]  push_data,
    input  logic [KEEP_WIDTH-1:0] push_keep,
    input  logic                  push_last,
    output logic                  slot_free,
    output logic [BUS_WIDTH-1:0]  out_tdata,
    output logic [KEEP_WIDTH-1:0] out_tkeep,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    input  logic                  out_tready
);

    assign slot_free = !out_tvalid || out_tready;

    // Non-push cycles carry zero data/keep, so an idle slot reads all zeros.
    always_ff @(posedge aclk) begin
        if (ARESET) begin
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            out_tdata  <= '0;
            out_tkeep  <= '0;
        end else if (slot_free) begin
            out_tvalid <= push_valid;
            out_tlast  <= push_last;
            out_tdata  <= push_data;
            out_tkeep  <= push_keep;
        end
    end

endmodule

// File: rtl/axis_keep_pack.sv
// Removes the leading null lanes of each packet's first beat and repacks bytes densely.
//
//   state    | meaning
//   ST_IDLE  | waiting for a packet's first beat
//   ST_ACC   | residue holds N-S bytes of the current packet
//   ST_FLUSH | residue holds the tail bytes that did not fit; input stalled
module axis_keep_pack
    import axis_keep_pack_pkg::*;
#(
    parameter int BUS_WIDTH   = 512,
    parameter int SHIFT_BYTES = 2,
    parameter int KEEP_WIDTH  = BUS_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  ARESET,
    input  logic [BUS_WIDTH-1:0]  in_tdata,
    input  logic [KEEP_WIDTH-1:0] in_tkeep,
    input  logic                  in_tvalid,
    input  logic                  in_tlast,
    output logic                  in_tready,
    output logic [BUS_WIDTH-1:0]  out_tdata,
    output logic [KEEP_WIDTH-1:0] out_tkeep,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    input  logic                  out_tready,
    output logic                  err
);

    localparam int SHIFT_BITS = SHIFT_BYTES * 8;
    localparam int RES_BITS   = (KEEP_WIDTH - SHIFT_BYTES) * 8;
    localparam logic [KEEP_WIDTH-1:0] FIRST_KEEP = ~KEEP_WIDTH'(keep_ones(SHIFT_BYTES));
    localparam logic [KEEP_WIDTH-1:0] ALL_KEEP   = '1;

    state_t                  state, state_nxt;
    logic [BUS_WIDTH-1:0]    r_data, r_nxt;
    logic [7:0]              flush_cnt, flush_nxt;
    logic                    bad;
    logic                    accept;
    logic                    slot_free;
    logic [BUS_WIDTH-1:0]    shifted, merged;
    keep_info_t              last_info;
    int                      last_b;

    logic                    push_valid;
    logic [BUS_WIDTH-1:0]    push_raw, push_data;
    logic [KEEP_WIDTH-1:0]   push_keep;
    logic                    push_last;

    assign in_tready = slot_free && (state != ST_FLUSH) && !ARESET;
    assign accept    = in_tvalid && in_tready;
    assign shifted   = in_tdata >> SHIFT_BITS;
    assign merged    = r_data | (in_tdata << RES_BITS);
    assign last_info = keep_count(KEEP_MAX'(in_tkeep));
    assign last_b    = int'(last_info.count);

    always_comb begin
        state_nxt  = state;
        r_nxt      = r_data;
        flush_nxt  = flush_cnt;
        bad        = 1'b0;
        push_valid = 1'b0;
        push_raw   = '0;
        push_keep  = '0;
        push_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    bad = (in_tkeep != FIRST_KEEP);
                    if (in_tlast) begin
                        push_valid = 1'b1;
                        push_raw   = shifted;
                        push_keep  = KEEP_WIDTH'(keep_ones(KEEP_WIDTH - SHIFT_BYTES));
                        push_last  = 1'b1;
                    end else begin
                        r_nxt     = shifted;
                        state_nxt = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (accept) begin
                    push_valid = 1'b1;
                    push_raw   = merged;
                    if (!in_tlast) begin
                        bad       = (in_tkeep != ALL_KEEP);
                        push_keep = ALL_KEEP;
                        r_nxt     = shifted;
                    end else begin
                        bad = !last_info.contig;
                        if (last_b <= SHIFT_BYTES) begin
                            push_keep = KEEP_WIDTH'(keep_ones(KEEP_WIDTH - SHIFT_BYTES + last_b));
                            push_last = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            // Tail overflows this beat; emit it full and spill the rest.
                            push_keep = ALL_KEEP;
                            r_nxt     = shifted;
                            flush_nxt = 8'(last_b - SHIFT_BYTES);
                            state_nxt = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    push_valid = 1'b1;
                    push_raw   = r_data;
                    push_keep  = KEEP_WIDTH'(keep_ones(int'(flush_cnt)));
                    push_last  = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        push_data = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            push_data[8*i +: 8] = push_raw[8*i +: 8] & {8{push_keep[i]}};
        end
    end

    always_ff @(posedge aclk) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            r_data    <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            r_data    <= r_nxt;
            flush_cnt <= flush_nxt;
            err       <= err | bad;
        end
    end

    axis_out_reg #(
        .BUS_WIDTH  (BUS_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_out_reg (
        .aclk       (aclk),
        .ARESET     (ARESET),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_keep  (push_keep),
        .push_last  (push_last),
        .slot_free  (slot_free),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tvalid (out_tvalid),
        .out_tlast  (out_tlast),
        .out_tready (out_tready)
    );

endmodule

// File: tb/tb_axis_keep_pack.sv
// Scoreboard bench for axis_keep_pack with N=4 lanes and one leading null lane.
module tb_axis_keep_pack;

    localparam int BW = 32;
    localparam int N  = 4;
    localparam int S  = 1;

    logic          aclk = 1'b0;
    logic          ARESET = 1'b1;
    logic [BW-1:0] in_tdata = '0;
    logic [N-1:0]  in_tkeep = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tlast = 1'b0;
    logic          in_tready;
    logic [BW-1:0] out_tdata;
    logic [N-1:0]  out_tkeep;
    logic          out_tvalid;
    logic          out_tlast;
    logic          out_tready = 1'b1;
    logic          err;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [BW-1:0] pk_data[$];
    logic [N-1:0]  pk_keep[$];
    int            checks = 0;
    int            errors = 0;
    logic          exp_err = 1'b0;
    int            ready_mode = 0;

    always #5 aclk = ~aclk;

    axis_keep_pack #(
        .BUS_WIDTH   (BW),
        .SHIFT_BYTES (S),
        .KEEP_WIDTH  (N)
    ) dut (
        .aclk       (aclk),
        .ARESET     (ARESET),
        .in_tdata   (in_tdata),
        .in_tkeep   (in_tkeep),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tvalid (out_tvalid),
        .out_tlast  (out_tlast),
        .out_tready (out_tready),
        .err        (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: gather the packet's real bytes, then cut into N-byte beats.
    task automatic model_packet();
        byte unsigned bytes[$];
        beat_t        b;
        for (int j = 0; j < pk_data.size(); j++) begin
            int lo;
            int hi;
            if (j == 0) begin
                lo = S; hi = N;
            end else if (j == pk_data.size() - 1) begin
                lo = 0; hi = $countones(pk_keep[j]);
            end else begin
                lo = 0; hi = N;
            end
            for (int l = lo; l < hi; l++) bytes.push_back(pk_data[j][8*l +: 8]);
        end
        while (bytes.size() > 0) begin
            b = '0;
            for (int l = 0; l < N && bytes.size() > 0; l++) begin
                b.data[8*l +: 8] = bytes.pop_front();
                b.keep[l] = 1'b1;
            end
            b.last = (bytes.size() == 0);
            exp_q.push_back(b);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat is accepted.
    task automatic send_beat(input logic [BW-1:0] d, input logic [N-1:0] k,
                             input logic l, input logic bad);
        logic rdy;
        int   n;
        n = 0;
        in_tdata = d; in_tkeep = k; in_tlast = l; in_tvalid = 1'b1;
        do begin
            @(negedge aclk);
            rdy = in_tready;
            @(posedge aclk); #1;
            n++;
        end while (!rdy && n < 300);
        check("accept_in_time", 64'(rdy), 64'd1);
        if (bad) exp_err = 1'b1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tdata  = $urandom;
        in_tkeep  = 4'($urandom);
    endtask

    task automatic send_pk(input logic push_model, input logic bad_first, input logic gaps);
        if (push_model) model_packet();
        for (int j = 0; j < pk_data.size(); j++) begin
            send_beat(pk_data[j], pk_keep[j], j == pk_data.size() - 1, (j == 0) && bad_first);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge aclk); #1;
            end
        end
    endtask

    task automatic build_random(input int nbeats, input int b, input logic bad_first);
        pk_data.delete(); pk_keep.delete();
        for (int j = 0; j < nbeats; j++) begin
            pk_data.push_back($urandom);
            if (j == 0) pk_keep.push_back(bad_first ? 4'b1111 : 4'b1110);
            else if (j == nbeats - 1) pk_keep.push_back(4'((1 << b) - 1));
            else pk_keep.push_back(4'b1111);
        end
    endtask

    task automatic load_scen1();
        pk_data.delete(); pk_keep.delete();
        pk_data.push_back(32'hA3A2A1EE); pk_keep.push_back(4'b1110);
        pk_data.push_back(32'hB3B2B1B0); pk_keep.push_back(4'b1111);
        pk_data.push_back(32'hEEEEC1C0); pk_keep.push_back(4'b0011);
        exp_q.push_back('{data: 32'hB0A3A2A1, keep: 4'b1111, last: 1'b0});
        exp_q.push_back('{data: 32'hC0B3B2B1, keep: 4'b1111, last: 1'b0});
        exp_q.push_back('{data: 32'h000000C1, keep: 4'b0001, last: 1'b1});
    endtask

    task automatic pulse_reset();
        ARESET = 1'b1;
        @(negedge aclk);
        check("in_tready_in_reset", 64'(in_tready), 64'd0);
        @(posedge aclk); #1;
        exp_err = 1'b0;
        ARESET = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge aclk);
            n++;
        end
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge aclk); #1;
            case (ready_mode)
                0: out_tready = 1'b1;
                1: out_tready = ($urandom_range(0, 2) != 0);
                default: out_tready = ~out_tready;
            endcase
        end
    end

    initial begin
        beat_t held;
        beat_t e;
        logic  held_v;
        held_v = 1'b0;
        forever begin
            @(negedge aclk);
            if (ARESET) begin
                held_v = 1'b0;
            end else begin
                check("err", 64'(err), 64'(exp_err));
                if (held_v) begin
                    check("stall_valid_held", 64'(out_tvalid), 64'd1);
                    check("stall_beat_held", 64'({out_tdata, out_tkeep, out_tlast}), 64'(held));
                end
                if (out_tvalid && !out_tready) begin
                    check("in_tready_when_full", 64'(in_tready), 64'd0);
                    held = '{data: out_tdata, keep: out_tkeep, last: out_tlast};
                    held_v = 1'b1;
                end else begin
                    held_v = 1'b0;
                end
                if (out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(out_tdata), 64'd0);
                        if (out_tdata == '0) begin
                            errors++;
                            $display("FAIL unexpected_beat: got beat with empty scoreboard");
                        end
                    end else begin
                        e = exp_q.pop_front();
                        check("out_tdata", 64'(out_tdata), 64'(e.data));
                        check("out_tkeep", 64'(out_tkeep), 64'(e.keep));
                        check("out_tlast", 64'(out_tlast), 64'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_in_tready", 64'(in_tready), 64'd0);
        check("reset_out_tvalid", 64'(out_tvalid), 64'd0);
        check("reset_out_tlast", 64'(out_tlast), 64'd0);
        check("reset_out_tdata", 64'(out_tdata), 64'd0);
        check("reset_out_tkeep", 64'(out_tkeep), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        @(posedge aclk); #1;
        ARESET = 1'b0;

        // Three-beat packet, b=2 > S: needs a flush beat and one input bubble.
        ready_mode = 0;
        load_scen1();
        send_beat(pk_data[0], pk_keep[0], 1'b0, 1'b0);
        @(negedge aclk);
        check("no_out_after_first", 64'(out_tvalid), 64'd0);
        @(posedge aclk); #1;
        send_beat(pk_data[1], pk_keep[1], 1'b0, 1'b0);
        @(negedge aclk);
        check("first_out_after_second", 64'(out_tvalid), 64'd1);
        @(posedge aclk); #1;
        send_beat(pk_data[2], pk_keep[2], 1'b1, 1'b0);
        @(negedge aclk);
        check("flush_bubble_in_tready", 64'(in_tready), 64'd0);
        @(posedge aclk); #1;
        drain();

        // Single-beat packet: output on the cycle after acceptance.
        exp_q.push_back('{data: 32'h00332211, keep: 4'b0111, last: 1'b1});
        send_beat(32'h332211EE, 4'b1110, 1'b1, 1'b0);
        @(negedge aclk);
        check("single_latency_valid", 64'(out_tvalid), 64'd1);
        check("single_latency_last", 64'(out_tlast), 64'd1);
        @(posedge aclk); #1;
        drain();

        // b=1 <= S: packs into one full last beat with no flush.
        exp_q.push_back('{data: 32'h44A3A2A1, keep: 4'b1111, last: 1'b1});
        send_beat(32'hA3A2A1EE, 4'b1110, 1'b0, 1'b0);
        send_beat(32'hEEEEEE44, 4'b0001, 1'b1, 1'b0);
        @(negedge aclk);
        check("no_flush_in_tready", 64'(in_tready), 64'd1);
        check("no_flush_last", 64'(out_tlast), 64'd1);
        @(posedge aclk); #1;
        drain();

        // Zero-byte last beat emits the residue alone.
        build_random(2, 0, 1'b0);
        send_pk(1'b1, 1'b0, 1'b0);
        drain();

        // Backpressure on alternate cycles.
        ready_mode = 2;
        load_scen1();
        send_pk(1'b0, 1'b0, 1'b0);
        drain();
        ready_mode = 0;
        @(posedge aclk); #1;

        // Reset mid-packet drops the partial packet.
        send_beat(32'hA3A2A1EE, 4'b1110, 1'b0, 1'b0);
        pulse_reset();
        @(negedge aclk);
        check("post_reset_out_tvalid", 64'(out_tvalid), 64'd0);
        check("post_reset_err", 64'(err), 64'd0);
        @(posedge aclk); #1;
        exp_q.push_back('{data: 32'h00665544, keep: 4'b0111, last: 1'b1});
        send_beat(32'h665544EE, 4'b1110, 1'b1, 1'b0);
        drain();

        // Format error on first beat: err sticky through clean packets.
        build_random(3, 2, 1'b1);
        send_pk(1'b1, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++) begin
            build_random(1 + p, 3, 1'b0);
            send_pk(1'b1, 1'b0, 1'b0);
        end
        drain();
        check("err_sticky", 64'(err), 64'd1);
        pulse_reset();
        @(negedge aclk);
        check("err_cleared", 64'(err), 64'd0);
        @(posedge aclk); #1;

        // Randomized packets with random downstream stalls and input gaps.
        ready_mode = 1;
        for (int p = 0; p < 60; p++) begin
            int nb;
            nb = $urandom_range(1, 5);
            build_random(nb, $urandom_range(0, N), 1'b0);
            send_pk(1'b1, 1'b0, 1'b1);
        end
        drain();
        ready_mode = 0;
        repeat (3) @(posedge aclk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
